// File: rtl/mac_dot_ctrl.sv
// mac_dot_ctrl: dot-product controller driving a combinational mac_unit.
// Streams operand pairs into the MAC, feeds the accumulator back as in_c,
// and returns one result (acc = init_c + sum(a*b)) plus a sticky error per
// vector over a valid/ready result port.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   start, vec_len,     begin a vector (sampled in IDLE); length, mode,
//   mode, init_c        and accumulator seed captured at start
//   s_valid/s_ready,    operand pair stream (s_a, s_b)
//   s_a, s_b
//   mac_a/b/c, mac_mode to mac_unit; mac_out/mac_err back from it
//   res_valid/res_ready result handshake; res_data, res_err payload
//   busy                high while a vector is in RUN or DONE
//
// Optional feature: define MAC_DOT_ERRCNT_EN to add err_cnt[7:0], the
// saturating count of accepted elements that raised mac_err.

module mac_dot_ctrl #(
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] vec_len,
    input  logic             mode,
    input  logic [15:0]      init_c,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [15:0]      s_a,
    input  logic [15:0]      s_b,
    output logic [15:0]      mac_a,
    output logic [15:0]      mac_b,
    output logic [15:0]      mac_c,
    output logic             mac_mode,
    input  logic [15:0]      mac_out,
    input  logic             mac_err,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [15:0]      res_data,
    output logic             res_err,
`ifdef MAC_DOT_ERRCNT_EN
    output logic [7:0]       err_cnt,
`endif
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [15:0]      acc_q, acc_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic             mode_q, mode_d;
    logic             err_q, err_d;
    logic             last_elem;

`ifdef MAC_DOT_ERRCNT_EN
    logic [7:0]       ecnt_q, ecnt_d;
`endif

    // cnt stops at len-1; the accept at that count closes the vector.
    assign last_elem = (cnt_q == (len_q - LEN_W'(1)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            len_q   <= '0;
            mode_q  <= 1'b0;
            err_q   <= 1'b0;
`ifdef MAC_DOT_ERRCNT_EN
            ecnt_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            mode_q  <= mode_d;
            err_q   <= err_d;
`ifdef MAC_DOT_ERRCNT_EN
            ecnt_q  <= ecnt_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        len_d     = len_q;
        mode_d    = mode_q;
        err_d     = err_q;
`ifdef MAC_DOT_ERRCNT_EN
        ecnt_d    = ecnt_q;
`endif
        s_ready   = 1'b0;
        res_valid = 1'b0;
        res_data  = '0;
        res_err   = 1'b0;
        busy      = 1'b0;
        mac_a     = '0;
        mac_b     = '0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    acc_d = init_c;
                    err_d = 1'b0;
`ifdef MAC_DOT_ERRCNT_EN
                    ecnt_d = '0;
`endif
                    // Zero-length vector skips RUN: result is the seed.
                    if (vec_len != '0) begin
                        state_d = RUN;
                        len_d   = vec_len;
                        cnt_d   = '0;
                        mode_d  = mode;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            RUN: begin
                busy    = 1'b1;
                s_ready = 1'b1;
                mac_a   = s_a;
                mac_b   = s_b;
                if (s_valid) begin
                    acc_d = mac_out;
                    err_d = err_q | mac_err;
`ifdef MAC_DOT_ERRCNT_EN
                    if (mac_err && (ecnt_q != 8'hFF)) begin
                        ecnt_d = ecnt_q + 8'd1;
                    end
`endif
                    if (last_elem) begin
                        state_d = DONE;
                    end else begin
                        cnt_d = cnt_q + LEN_W'(1);
                    end
                end
            end
            DONE: begin
                busy      = 1'b1;
                res_valid = 1'b1;
                res_data  = acc_q;
                res_err   = err_q;
                // start in the handshake cycle is not seen: IDLE first.
                if (res_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign mac_c    = acc_q;
    assign mac_mode = mode_q;

`ifdef MAC_DOT_ERRCNT_EN
    assign err_cnt = ecnt_q;
`endif

endmodule
